// File: rtl/car_pkg.sv
// Shared vehicle-lamp definitions: controller state encoding and default blink
// timing, so every lamp block on the board flashes in step.
package car_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEFT   = 3'd1,
    ST_RIGHT  = 3'd2,
    ST_LANE_L = 3'd3,
    ST_LANE_R = 3'd4,
    ST_HAZARD = 3'd5,
    ST_ESS    = 3'd6,
    ST_RSVD   = 3'd7
  } state_t;

  // 0.25 s normal phase and 62.5 ms emergency phase at 50 MHz.
  localparam int unsigned HALF_PERIOD_DEFAULT     = 12_500_000;
  localparam int unsigned ESS_HALF_PERIOD_DEFAULT = 3_125_000;
  localparam int unsigned LANE_FLASHES_DEFAULT    = 3;

endpackage

// File: rtl/blink_phase_gen.sv
// ON/OFF phase generator with restart, hold-off in idle and a selectable
// fast half period; exposes the upcoming phase so lamps can be registered from it.
module blink_phase_gen #(
  parameter int unsigned HALF_PERIOD     = 12_500_000,
  parameter int unsigned ESS_HALF_PERIOD = 3_125_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  input  logic fast,
  output logic phase,
  output logic phase_next,
  output logic phase_end,
  output logic off_edge
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(ESS_HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             phase_reg;

  // Terminal count is judged against the current mode's period only, so the
  // edge strobes never depend on the restart/enable decision they feed.
  assign phase_end = (cnt_reg == (fast ? FAST_LAST : SLOW_LAST));
  assign off_edge  = phase_reg && phase_end;
  assign phase     = phase_reg;

  always_comb begin
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    if (!enable) begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (restart) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (phase_end) begin
      cnt_next   = '0;
      phase_next = ~phase_reg;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

endmodule

// File: rtl/turn_signal_controller.sv
// Turn-indicator sequencer: prioritised arbitration of ESS, hazard, switches
// and lane-change taps, with a finite lane-change flash sequence.
module turn_signal_controller
  import car_pkg::*;
#(
  parameter int unsigned HALF_PERIOD     = HALF_PERIOD_DEFAULT,
  parameter int unsigned ESS_HALF_PERIOD = ESS_HALF_PERIOD_DEFAULT,
  parameter int unsigned LANE_FLASHES    = LANE_FLASHES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_hazard,
  input  logic       ess_active,
  input  logic       lane_left,
  input  logic       lane_right,
  output logic       led_left,
  output logic       led_right,
  output logic [2:0] mode,
  output logic       lane_busy
);

  localparam int FLASH_W = $clog2(LANE_FLASHES + 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(LANE_FLASHES);

  state_t             state_reg;
  state_t             state_next;
  logic [FLASH_W-1:0] flash_reg;
  logic [FLASH_W-1:0] flash_next;
  logic               led_left_reg;
  logic               led_left_next;
  logic               led_right_reg;
  logic               led_right_next;
  logic               lane_busy_reg;
  logic               lane_busy_next;

  logic restart;
  logic enable;
  logic fast;
  logic phase;
  logic phase_next;
  logic phase_end;
  logic off_edge;
  logic lane_done;
  logic in_lane;

  assign restart = (state_next != state_reg);
  assign enable  = (state_next != ST_IDLE);
  assign fast    = (state_reg == ST_ESS);
  assign in_lane = (state_reg == ST_LANE_L) || (state_reg == ST_LANE_R);
  // Sequence ends where the last OFF phase would hand back to ON.
  assign lane_done = (flash_reg == FLASH_LAST) && !phase && phase_end;

  blink_phase_gen #(
    .HALF_PERIOD     (HALF_PERIOD),
    .ESS_HALF_PERIOD (ESS_HALF_PERIOD)
  ) u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .enable     (enable),
    .fast       (fast),
    .phase      (phase),
    .phase_next (phase_next),
    .phase_end  (phase_end),
    .off_edge   (off_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      flash_reg     <= '0;
      led_left_reg  <= 1'b0;
      led_right_reg <= 1'b0;
      lane_busy_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flash_reg     <= flash_next;
      led_left_reg  <= led_left_next;
      led_right_reg <= led_right_next;
      lane_busy_reg <= lane_busy_next;
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    if (state_reg == ST_RSVD) begin
      state_next = ST_IDLE;
    end else if (ess_active) begin
      state_next = ST_ESS;
    end else if (sw_hazard) begin
      state_next = ST_HAZARD;
    end else if (sw_left ^ sw_right) begin
      state_next = sw_left ? ST_LEFT : ST_RIGHT;
    end else if (in_lane && !lane_done) begin
      state_next = state_reg;
    end else if ((state_reg == ST_IDLE) && (lane_left ^ lane_right)) begin
      state_next = lane_left ? ST_LANE_L : ST_LANE_R;
    end

    flash_next = flash_reg;
    if (restart) begin
      flash_next = '0;
    end else if (off_edge && (flash_reg != FLASH_LAST)) begin
      flash_next = flash_reg + 1'b1;
    end
  end

  // Lamps are registered from the upcoming state and phase, giving one cycle
  // from request to light with mode and lamps changing together.
  always_comb begin
    led_left_next  = 1'b0;
    led_right_next = 1'b0;
    lane_busy_next = (state_next == ST_LANE_L) || (state_next == ST_LANE_R);
    if (phase_next) begin
      led_left_next  = state_next inside {ST_LEFT, ST_LANE_L, ST_HAZARD, ST_ESS};
      led_right_next = state_next inside {ST_RIGHT, ST_LANE_R, ST_HAZARD, ST_ESS};
    end
  end

  assign led_left  = led_left_reg;
  assign led_right = led_right_reg;
  assign lane_busy = lane_busy_reg;
  assign mode      = state_reg;

endmodule
